// File: rtl/mcu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcu_pkg
// Purpose  : Opcodes, state codes and ALU op codes for the multi-cycle sequencer
// Revision : 1.0
// ============================================================================
package mcu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_LS = 4'd3,
    S_EXE_BR = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CL_AL   = 3'd0,
    CL_LS   = 3'd1,
    CL_BR   = 3'd2,
    CL_HALT = 3'd3,
    CL_BAD  = 3'd4
  } op_class_t;

  function automatic op_class_t op_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_ORI,
      OP_AND, OP_OR, OP_MOVE:        return CL_AL;
      OP_SW, OP_LW:                  return CL_LS;
      OP_BEQ:                        return CL_BR;
      OP_HALT:                       return CL_HALT;
      default:                       return CL_BAD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_decode.sv
`default_nettype none
// ============================================================================
// Module   : mcu_decode
// Purpose  : Per-opcode datapath mux / ALU selection; zero for non-ALU opcodes
// Revision : 1.0
// ============================================================================
module mcu_decode
  import mcu_pkg::*;
(
  input  logic [5:0] op,
  output logic       extsel,
  output logic       regout,
  output logic       alusrcb,
  output logic [2:0] aluop
);

  always_comb begin
    extsel  = 1'b0;
    regout  = 1'b0;
    alusrcb = 1'b0;
    aluop   = ALU_ADD;
    case (op)
      OP_ADD, OP_MOVE: begin extsel = 1'b1; regout = 1'b1; end
      OP_SUB:          begin extsel = 1'b1; regout = 1'b1; aluop = ALU_SUB; end
      OP_ADDI:         begin extsel = 1'b1; alusrcb = 1'b1; end
      OP_ORI:          begin alusrcb = 1'b1; aluop = ALU_OR; end
      OP_AND:          begin regout = 1'b1; aluop = ALU_AND; end
      OP_OR:           begin regout = 1'b1; aluop = ALU_OR; end
      OP_SW, OP_LW:    begin extsel = 1'b1; alusrcb = 1'b1; end
      OP_BEQ:          begin extsel = 1'b1; aluop = ALU_SUB; end
      default:         ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : IF/ID/EXE/MEM/WB sequencer with retire counter and illegal flag
// Revision : 1.0
// ============================================================================
module multicycle_control_unit
  import mcu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  output logic        PCWre,
  output logic        InsMemRW,
  output logic        IRWre,
  output logic        Extsel,
  output logic        RegOut,
  output logic        RegWre,
  output logic [2:0]  ALUOp,
  output logic        ALUSrcB,
  output logic        ALUM2Reg,
  output logic        PCSrc,
  output logic        DataMemRW,
  output logic [3:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_count
);

  state_t      r_state;
  logic [5:0]  r_op;
  logic        r_illegal;
  logic [15:0] r_count;

  logic [5:0]  w_dec_op;
  logic        w_extsel;
  logic        w_regout;
  logic        w_alusrcb;
  logic [2:0]  w_aluop;
  logic        w_in_instr;

  // The IR is valid during ID but r_op only captures it on leaving ID.
  assign w_dec_op   = (r_state == S_ID) ? opcode : r_op;
  assign w_in_instr = (r_state != S_IF) && (r_state != S_HALT);

  mcu_decode u_decode (
    .op      (w_dec_op),
    .extsel  (w_extsel),
    .regout  (w_regout),
    .alusrcb (w_alusrcb),
    .aluop   (w_aluop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IF;
      r_op      <= 6'd0;
      r_illegal <= 1'b0;
      r_count   <= 16'd0;
    end else begin
      if (PCWre) r_count <= r_count + 16'd1;
      case (r_state)
        S_IF: r_state <= S_ID;
        S_ID: begin
          r_op <= opcode;
          case (op_class(opcode))
            CL_AL:   r_state <= S_EXE_AL;
            CL_LS:   r_state <= S_EXE_LS;
            CL_BR:   r_state <= S_EXE_BR;
            CL_HALT: r_state <= S_HALT;
            default: begin
              r_state   <= S_IF;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_EXE_AL: r_state <= S_WB_AL;
        S_EXE_LS: r_state <= S_MEM;
        S_MEM:    r_state <= (r_op == OP_LW) ? S_WB_LD : S_IF;
        S_EXE_BR: r_state <= S_IF;
        S_WB_AL:  r_state <= S_IF;
        S_WB_LD:  r_state <= S_IF;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IF;
      endcase
    end
  end

  always_comb begin
    PCWre     = 1'b0;
    InsMemRW  = 1'b0;
    IRWre     = (r_state == S_IF);
    Extsel    = 1'b0;
    RegOut    = 1'b0;
    RegWre    = 1'b0;
    ALUOp     = ALU_ADD;
    ALUSrcB   = 1'b0;
    ALUM2Reg  = 1'b0;
    PCSrc     = 1'b0;
    DataMemRW = 1'b0;
    if (w_in_instr) begin
      Extsel  = w_extsel;
      RegOut  = w_regout;
      ALUSrcB = w_alusrcb;
      ALUOp   = w_aluop;
    end
    case (r_state)
      S_EXE_BR: begin PCWre = 1'b1; PCSrc = zero; end
      S_MEM: begin
        if (r_op == OP_SW) begin
          DataMemRW = 1'b1;
          PCWre     = 1'b1;
        end
      end
      S_WB_AL: begin RegWre = 1'b1; PCWre = 1'b1; end
      S_WB_LD: begin RegWre = 1'b1; ALUM2Reg = 1'b1; PCWre = 1'b1; end
      default: ;
    endcase
  end

  assign state       = r_state;
  assign halted      = (r_state == S_HALT);
  assign illegal     = r_illegal;
  assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Purpose  : Table, random and directed checks against an instruction-timeline model
// Revision : 1.0
// ============================================================================
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        PCWre, InsMemRW, IRWre, Extsel, RegOut, RegWre;
  logic [2:0]  ALUOp;
  logic        ALUSrcB, ALUM2Reg, PCSrc, DataMemRW;
  logic [3:0]  state;
  logic        halted, illegal;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .InsMemRW(InsMemRW), .IRWre(IRWre), .Extsel(Extsel),
    .RegOut(RegOut), .RegWre(RegWre), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .ALUM2Reg(ALUM2Reg), .PCSrc(PCSrc), .DataMemRW(DataMemRW),
    .state(state), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        pcwre, insmemrw, irwre, extsel, regout, regwre;
    logic [2:0]  aluop;
    logic        alusrcb, alum2reg, pcsrc, datamemrw, hlt, ill;
    logic [15:0] cnt;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       extsel, regout, alusrcb;
    logic [2:0] aluop;
    int         cycles;
    int         zmode;   // -1: random zero in EXE_BR, else forced value
    string      name;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  logic  m_illegal;
  logic [15:0] m_count;
  vec_t  vecs[12];

  function automatic vec_t mk(logic [5:0] op, logic e, logic r, logic b,
                              logic [2:0] a, int c, int zm, string n);
    vec_t v;
    v.op = op; v.extsel = e; v.regout = r; v.alusrcb = b;
    v.aluop = a; v.cycles = c; v.zmode = zm; v.name = n;
    return v;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.st = state; o.pcwre = PCWre; o.insmemrw = InsMemRW; o.irwre = IRWre;
    o.extsel = Extsel; o.regout = RegOut; o.regwre = RegWre; o.aluop = ALUOp;
    o.alusrcb = ALUSrcB; o.alum2reg = ALUM2Reg; o.pcsrc = PCSrc;
    o.datamemrw = DataMemRW; o.hlt = halted; o.ill = illegal;
    o.cnt = instr_count;
    return o;
  endfunction

  function automatic outs_t quiet(logic [3:0] st);
    outs_t e = '0;
    e.st = st; e.cnt = m_count; e.ill = m_illegal;
    e.irwre = (st == 4'd0);
    e.hlt = (st == 4'd8);
    return e;
  endfunction

  // Expected outputs in cycle k of an instruction, from its class and length.
  function automatic outs_t model(vec_t v, int k, logic z);
    outs_t e = '0;
    logic is_sw = (v.op == 6'b100110);
    logic is_lw = (v.op == 6'b100111);
    logic is_br = (v.op == 6'b110000);
    logic is_al = !is_sw && !is_lw && !is_br;
    logic last  = (k == v.cycles - 1);
    e.cnt = m_count; e.ill = m_illegal;
    case (k)
      0: e.st = 4'd0;
      1: e.st = 4'd1;
      2: e.st = is_al ? 4'd2 : (is_br ? 4'd4 : 4'd3);
      3: e.st = is_al ? 4'd6 : 4'd5;
      default: e.st = 4'd7;
    endcase
    e.irwre     = (k == 0);
    e.pcwre     = last;
    e.regwre    = last && (is_al || is_lw);
    e.datamemrw = is_sw && (k == 3);
    e.alum2reg  = is_lw && (k == 4);
    e.pcsrc     = is_br && (k == 2) && z;
    if (k >= 1) begin
      e.extsel = v.extsel; e.regout = v.regout;
      e.alusrcb = v.alusrcb; e.aluop = v.aluop;
    end
    return e;
  endfunction

  task automatic check(string name, int k, outs_t exp);
    outs_t act = sample();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: actual=%h required=%h", name, k, act, exp);
    end
  endtask

  // Entered just after a rising edge with the DUT in IF; leaves it the same way.
  task automatic run(vec_t v, string tag, int stop);
    logic z;
    for (int k = 0; k < v.cycles && k < stop; k++) begin
      opcode = (k == 0) ? 6'($urandom) : v.op;
      z = 1'($urandom);
      if (k == 2 && v.zmode >= 0) z = v.zmode[0];
      zero = z;
      @(negedge clk);
      check({tag, "_", v.name}, k, model(v, k, z));
      @(posedge clk); #1;
      if (k == v.cycles - 1) m_count = m_count + 16'd1;
    end
  endtask

  task automatic reset_pulse(string tag);
    rst_n = 1'b0;
    m_count = 16'd0; m_illegal = 1'b0;
    #1 check(tag, 0, quiet(4'd0));
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(6'b000000, 1, 1, 0, 3'b000, 4, -1, "add");
    vecs[1]  = mk(6'b000001, 1, 0, 1, 3'b000, 4, -1, "addi");
    vecs[2]  = mk(6'b000010, 1, 1, 0, 3'b001, 4, -1, "sub");
    vecs[3]  = mk(6'b010000, 0, 0, 1, 3'b011, 4, -1, "ori");
    vecs[4]  = mk(6'b010001, 0, 1, 0, 3'b100, 4, -1, "and");
    vecs[5]  = mk(6'b010010, 0, 1, 0, 3'b011, 4, -1, "or");
    vecs[6]  = mk(6'b100000, 1, 1, 0, 3'b000, 4, -1, "move");
    vecs[7]  = mk(6'b100111, 1, 0, 1, 3'b000, 5, -1, "lw");
    vecs[8]  = mk(6'b100110, 1, 0, 1, 3'b000, 4, -1, "sw");
    vecs[9]  = mk(6'b110000, 1, 0, 0, 3'b001, 3,  1, "beq_z1");
    vecs[10] = mk(6'b110000, 1, 0, 0, 3'b001, 3,  0, "beq_z0");
    vecs[11] = mk(6'b110000, 1, 0, 0, 3'b001, 3, -1, "beq_zr");

    rst_n = 1'b0; opcode = 6'd0; zero = 1'b1;
    m_count = 16'd0; m_illegal = 1'b0;
    @(negedge clk);
    check("reset", 0, quiet(4'd0));
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run(vecs[i], "table", 99);
    for (int i = 0; i < 40; i++) run(vecs[$urandom_range(0, 11)], "rand", 99);

    // Undefined opcode: back to IF, flag set, nothing retired.
    opcode = 6'($urandom); zero = 1'b1;
    @(negedge clk); check("illegal_if", 0, quiet(4'd0));
    @(posedge clk); #1 opcode = 6'b001111;
    @(negedge clk); check("illegal_id", 1, quiet(4'd1));
    @(posedge clk); #1 m_illegal = 1'b1;
    run(vecs[0], "after_illegal", 99);

    // Halt: parks with all controls low and the count frozen.
    opcode = 6'($urandom);
    @(negedge clk); check("halt_if", 0, quiet(4'd0));
    @(posedge clk); #1 opcode = 6'b111111;
    @(negedge clk); check("halt_id", 1, quiet(4'd1));
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1 opcode = 6'($urandom); zero = 1'($urandom);
      @(negedge clk); check("halt_park", c, quiet(4'd8));
    end
    @(posedge clk); #1;
    reset_pulse("reset_from_halt");

    // Reset in the MEM cycle of sw must drop DataMemRW at once.
    run(vecs[0], "pre", 99);
    run(vecs[8], "sw_head", 3);
    zero = 1'b0;
    @(negedge clk); check("sw_mem", 3, model(vecs[8], 3, 1'b0));
    #2 reset_pulse("reset_in_mem");
    run(vecs[2], "post_reset", 99);

    // Counter wrap from 0xFFFF.
    force dut.r_count = 16'hFFFF;
    #1 release dut.r_count;
    m_count = 16'hFFFF;
    run(vecs[9], "wrap", 99);
    run(vecs[5], "wrapped", 99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style sequencer for the multi-cycle version of the CPU datapath. It steps each instruction through IF, ID, EXE, MEM and WB states and drives the same control signal set as the single-cycle decoder, plus an instruction-register load enable. Writes and PC updates occur only in their owning state, so the PC, register file, data memory and IR each see at most one write per instruction. The unit sits between the instruction register's opcode field and the ALU zero flag on one side and the datapath muxes and write enables on the other.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes occur on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; stable from the cycle after IF.
- zero  in  1  ALU zero flag; sampled only in EXE_BR.
- PCWre  out  1  PC write enable; one-cycle pulse at instruction retire.
- InsMemRW  out  1  constant 0 (read only).
- IRWre  out  1  IR load enable; 1 only in IF.
- Extsel  out  1  immediate extension: 1 = sign, 0 = zero (ori/and/or).
- RegOut  out  1  destination select: 0 = rt, 1 = rd.
- RegWre  out  1  register-file write enable; 1 only in WB_AL and WB_LD.
- ALUOp  out  3  000 add, 001 sub, 011 or, 100 and.
- ALUSrcB  out  1  0 = rt, 1 = extended immediate.
- ALUM2Reg  out  1  write-back source: 1 = memory (lw only).
- PCSrc  out  1  1 = branch target; equals zero in EXE_BR, else 0.
- DataMemRW  out  1  data-memory write; 1 only in MEM for sw.
- state  out  4  current state code, for debug.
- halted  out  1  1 while in HALT.
- illegal  out  1  sticky; set when an undefined opcode is decoded in ID.
- instr_count  out  16  retired-instruction count; wraps.

## Operation
- States: IF, ID, EXE_AL, EXE_LS, EXE_BR, MEM, WB_AL, WB_LD, HALT.
- IF → ID, always.
- ID, by opcode:
  - add 000000, addi 000001, sub 000010, ori 010000, and 010001, or 010010, move 100000 → EXE_AL.
  - sw 100110, lw 100111 → EXE_LS.
  - beq 110000 → EXE_BR.
  - halt 111111 → HALT.
  - Any other opcode → IF, and set illegal. The instruction is treated as a nop: no PCWre and no count.
- EXE_AL → WB_AL.
- EXE_LS → MEM.
- MEM → WB_LD for lw; → IF for sw (retire).
- EXE_BR → IF (retire).
- WB_AL → IF and WB_LD → IF (retire).
- HALT → HALT until rst_n is asserted.
- Control signals per opcode, held from ID through the end of the instruction:

  | Group | Extsel | RegOut | ALUSrcB | ALUOp |
  |---|---|---|---|---|
  | add, move | 1 | 1 | 0 | 000 |
  | sub | 1 | 1 | 0 | 001 |
  | addi | 1 | 0 | 1 | 000 |
  | ori | 0 | 0 | 1 | 011 |
  | and | 0 | 1 | 0 | 100 |
  | or | 0 | 1 | 0 | 011 |
  | sw, lw | 1 | 0 | 1 | 000 |
  | beq | 1 | 0 | 0 | 001 |

- Write enables and muxes outside their owning state:
  - RegWre, DataMemRW, PCWre and ALUM2Reg are 0.
  - In IF, muxes are 0 and ALUOp = 000.
- Retire rules:
  - PCWre = 1 in the retire states WB_AL, WB_LD, MEM for sw, and EXE_BR.
  - instr_count increments on the same edge as PCWre.
  - Count wraps from 0xFFFF to 0x0000.
- The halt instruction is not counted and never raises PCWre.
- An undefined opcode does not advance the PC. The unit re-fetches the same instruction forever; illegal flags it to the bench.

## Timing
- Cycles per instruction:
  - beq: 3 (IF, ID, EXE_BR).
  - ALU ops: 4.
  - sw: 4.
  - lw: 5.
  - halt reaches HALT 2 cycles after entering IF.
- Outputs are combinational decodes of state, plus the registered opcode group. PCSrc is the only Mealy term: PCSrc = zero when state = EXE_BR.
- Reset values while rst_n = 0, and on the first cycle after release:
  - state = IF.
  - IRWre = 1.
  - All other control outputs = 0.
  - halted = 0, illegal = 0, instr_count = 0.
- Reset asserted mid-instruction aborts the instruction immediately. No partial write is completed after rst_n falls.
- zero is ignored in every state except EXE_BR.

## Structure
- Package mcu_pkg holds:
  - Opcode localparams (OP_ADD … OP_HALT).
  - State encodings: IF = 0, ID = 1, EXE_AL = 2, EXE_LS = 3, EXE_BR = 4, MEM = 5, WB_AL = 6, WB_LD = 7, HALT = 8.
  - ALUOp constants.
- The per-opcode decode of Extsel, RegOut, ALUSrcB and ALUOp is split into a combinational sub-module, mcu_decode. The FSM, counter and illegal flag stay in the top module.

## Test plan
- Reset, then add → states IF, ID, EXE_AL, WB_AL, IF. RegWre = 1 only in WB_AL; PCWre pulses once; instr_count = 1.
- lw then sw → lw takes 5 cycles with ALUM2Reg = 1 and RegWre in WB_LD. sw takes 4 cycles with DataMemRW = 1 only in MEM and RegWre never asserted.
- beq with zero = 1, then beq with zero = 0 → PCSrc = 1 for the first and 0 for the second, both in EXE_BR. Each takes 3 cycles and PCWre pulses for both.
- ori and or → Extsel = 0 with ALUOp = 011 for both; ALUSrcB = 1 for ori and 0 for or.
- Opcode 001111 → illegal = 1, state returns to IF, no PCWre, count unchanged. halt → halted = 1, outputs frozen to 0 for 20 cycles, count unchanged.
- rst_n pulsed low during MEM of sw → DataMemRW drops asynchronously, state = IF, count = 0. Preload count 0xFFFF and retire one instruction → count = 0x0000.
